fir_mc: RTL and testbench

Parametrised multi-channel FIR filter built around a single time-shared multiply-accumulate unit. It keeps an independent sample delay line per channel and one shared coefficient set. Coefficients load through a serial shift chain. Samples enter and results leave through valid/ready handshakes. It is the next-generation replacement for the fixed single-channel FIR in the DSP datapath, adding channel multiplexing, flow control and runtime signed/unsigned mode.

---
 rtl/fir_mc_pkg.sv | 23 ++
 rtl/fir_mc_mac.sv | 56 +++++
 rtl/fir_mc.sv | 173 +++++++++++++++++
 tb/tb_fir_mc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mc_pkg.sv
// Shared types and helpers for the multi-channel time-shared FIR filter.
package fir_mc_pkg;

  // Controller phases: waiting for a sample, stepping through taps, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Channel index width; a single channel still needs a one-bit port.
  function automatic int ch_width(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  // The accumulator must hold a full product, and a filter needs at least two taps.
  function automatic bit params_legal(input int data_w, input int coef_w,
                                      input int out_w, input int order,
                                      input int channels);
    return (out_w >= data_w + coef_w) && (order >= 2) && (channels >= 1);
  endfunction

endpackage

// File: rtl/fir_mc_mac.sv
// Single multiply-accumulate slice: tc-aware product, extension to the
// accumulator width, and the accumulator register itself.
module fir_mc_mac
  import fir_mc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [OUT_W-1:0]  init_val,
  input  logic              tc,
  input  logic [COEF_W-1:0] coef,
  input  logic [DATA_W-1:0] sample,
  output logic [OUT_W-1:0]  acc,
  output logic [OUT_W-1:0]  sum_next
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] sample_s;
  logic signed [PW-1:0] coef_s;
  logic signed [PW-1:0] prod_s;
  logic        [PW-1:0] prod_u;
  logic        [OUT_W-1:0] prod_ext;

  // Form both signed and unsigned products at full width, then extend the selected one.
  always_comb begin
    sample_s = PW'($signed(sample));
    coef_s   = PW'($signed(coef));
    prod_s   = sample_s * coef_s;
    prod_u   = PW'(sample) * PW'(coef);
    if (tc) begin
      prod_ext = OUT_W'(prod_s);
    end else begin
      prod_ext = OUT_W'(prod_u);
    end
  end

  assign sum_next = acc + prod_ext;

  // Accumulator: seeded with the start value on load, wraps modulo 2^OUT_W while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= init_val;
    end else if (en) begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/fir_mc.sv
// Multi-channel FIR: shared serial-load coefficient chain, one delay line per
// channel, and a controller that reuses one MAC for every tap.
module fir_mc
  import fir_mc_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int COEF_W   = 8,
  parameter  int OUT_W    = 18,
  parameter  int ORDER    = 6,
  parameter  int CHANNELS = 2,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_shift_en,
  input  logic [COEF_W-1:0] coef_in,
  output logic [COEF_W-1:0] coef_out,
  input  logic              tc,
  input  logic [OUT_W-1:0]  init_acc_val,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch
);

  localparam int K_W = $clog2(ORDER);

  if (!params_legal(DATA_W, COEF_W, OUT_W, ORDER, CHANNELS)) begin : g_param_check
    $error("fir_mc: illegal parameter combination");
  end

  state_t state_q;
  state_t state_d;

  logic [COEF_W-1:0] coef_q  [ORDER];
  logic [DATA_W-1:0] xline_q [CHANNELS][ORDER];

  logic [K_W-1:0]    k_q;
  logic [CH_W-1:0]   ch_q;
  logic              tc_q;

  logic              accept;
  logic              ch_legal;
  logic              start;
  logic              last_tap;
  logic              coef_shift;
  logic [COEF_W-1:0] mac_coef;
  logic [DATA_W-1:0] mac_sample;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  sum_next;

  // A coefficient shift in IDLE takes priority over accepting a sample.
  assign in_ready   = (state_q == IDLE) && !coef_shift_en;
  assign accept     = in_valid && in_ready;
  assign start      = accept && ch_legal;
  assign last_tap   = (k_q == K_W'(ORDER - 1));
  assign coef_shift = coef_shift_en && (state_q == IDLE);
  assign coef_out   = coef_q[ORDER-1];
  assign out_valid  = (state_q == DONE);

  // Channel numbers at or above CHANNELS are accepted but silently dropped.
  always_comb begin
    ch_legal = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_ch == CH_W'(c)) ch_legal = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start on a legal accept, finish after the last tap, release on out_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = MAC;
      MAC:     if (last_tap)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Coefficient chain: only moves while idle so a running computation sees stable taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) coef_q[k] <= '0;
    end else if (coef_shift) begin
      coef_q[0] <= coef_in;
      for (int k = 1; k < ORDER; k++) coef_q[k] <= coef_q[k-1];
    end
  end

  // Delay lines: the addressed channel shifts in the new sample on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < ORDER; t++) xline_q[c][t] <= '0;
      end
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_ch == CH_W'(c)) begin
          xline_q[c][0] <= in_data;
          for (int t = 1; t < ORDER; t++) xline_q[c][t] <= xline_q[c][t-1];
        end
      end
    end
  end

  // Per-computation context: channel and arithmetic mode captured at start, tap index stepped in MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q  <= '0;
      ch_q <= '0;
      tc_q <= 1'b0;
    end else if (start) begin
      k_q  <= '0;
      ch_q <= in_ch;
      tc_q <= tc;
    end else if (state_q == MAC) begin
      k_q  <= k_q + K_W'(1);
    end
  end

  // Tap operand selection for the current channel and tap index.
  always_comb begin
    mac_coef   = '0;
    mac_sample = '0;
    for (int t = 0; t < ORDER; t++) begin
      if (k_q == K_W'(t)) mac_coef = coef_q[t];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      for (int t = 0; t < ORDER; t++) begin
        if ((ch_q == CH_W'(c)) && (k_q == K_W'(t))) mac_sample = xline_q[c][t];
      end
    end
  end

  fir_mc_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .en       (state_q == MAC),
    .init_val (init_acc_val),
    .tc       (tc_q),
    .coef     (mac_coef),
    .sample   (mac_sample),
    .acc      (acc),
    .sum_next (sum_next)
  );

  // Result register: captures the final sum on the last tap and holds it through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if ((state_q == MAC) && last_tap) begin
      out_data <= sum_next;
      out_ch   <= ch_q;
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Self-checking bench for fir_mc: directed vectors, a behavioural FIR model
// with an output scoreboard, and literal expectations for known cases.
module tb_fir_mc;

  // Three channels so that a 2-bit channel field can address a non-existent channel (3).
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int OUT_W    = 18;
  localparam int ORDER    = 6;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              coef_shift_en = 1'b0;
  logic [COEF_W-1:0] coef_in = '0;
  logic [COEF_W-1:0] coef_out;
  logic              tc = 1'b0;
  logic [OUT_W-1:0]  init_acc_val = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CH_W-1:0]   in_ch = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic [CH_W-1:0]   out_ch;

  fir_mc #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .OUT_W    (OUT_W),
    .ORDER    (ORDER),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coef_shift_en (coef_shift_en),
    .coef_in       (coef_in),
    .coef_out      (coef_out),
    .tc            (tc),
    .init_acc_val  (init_acc_val),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_ch         (in_ch),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ch        (out_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [CH_W-1:0]  ch;
  } result_t;

  int      checks   = 0;
  int      failures = 0;
  bit      check_en = 1'b0;
  result_t exp_q[$];
  result_t obs_q[$];

  logic [COEF_W-1:0] coef_m [ORDER];
  logic [DATA_W-1:0] x_m    [CHANNELS][ORDER];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void modelClear();
    for (int k = 0; k < ORDER; k++) coef_m[k] = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int k = 0; k < ORDER; k++) x_m[c][k] = '0;
  endfunction

  // Plain FIR sum: init + sum of c[k]*x[k], signed or unsigned, reduced modulo 2^OUT_W.
  function automatic logic [OUT_W-1:0] modelResult(input int ch, input logic t, input logic [OUT_W-1:0] init);
    longint s;
    s = longint'(init);
    for (int k = 0; k < ORDER; k++) begin
      if (t) s += longint'($signed(coef_m[k])) * longint'($signed(x_m[ch][k]));
      else   s += longint'(coef_m[k]) * longint'(x_m[ch][k]);
    end
    return OUT_W'(s);
  endfunction

  // Scoreboard: every cycle with a result present is compared against the model's oldest expectation.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      checkOutput("ready_valid_exclusive", {63'd0, in_ready & out_valid}, 64'd0);
      if (out_valid) begin
        checkOutput("unexpected_output", {63'd0, exp_q.size() == 0}, 64'd0);
        if (exp_q.size() != 0) begin
          checkOutput("out_data", 64'(out_data), 64'(exp_q[0].data));
          checkOutput("out_ch", 64'(out_ch), 64'(exp_q[0].ch));
          if (out_ready) begin
            obs_q.push_back('{data: out_data, ch: out_ch});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic applyCoef(input logic [COEF_W-1:0] v);
    @(posedge clk); #1;
    coef_shift_en = 1'b1;
    coef_in       = v;
    @(posedge clk);
    for (int k = ORDER - 1; k > 0; k--) coef_m[k] = coef_m[k-1];
    coef_m[0] = v;
    #1 coef_shift_en = 1'b0;
  endtask

  task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] d, input logic t, input logic [OUT_W-1:0] init);
    int n;
    @(posedge clk); #1;
    in_valid     = 1'b1;
    in_ch        = CH_W'(ch);
    in_data      = d;
    tc           = t;
    init_acc_val = init;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready && ch < CHANNELS) begin
      for (int k = ORDER - 1; k > 0; k--) x_m[ch][k] = x_m[ch][k-1];
      x_m[ch][0] = d;
      exp_q.push_back('{data: modelResult(ch, t, init), ch: CH_W'(ch)});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic checkNextObs(input string name, input logic [OUT_W-1:0] d, input logic [CH_W-1:0] c);
    result_t r;
    checkOutput({name, "_present"}, {63'd0, obs_q.size() > 0}, 64'd1);
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      checkOutput({name, "_data"}, 64'(r.data), 64'(d));
      checkOutput({name, "_ch"}, 64'(r.ch), 64'(c));
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    obs_q.delete();
    modelClear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Global time bound so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [OUT_W-1:0] imp_exp [7];
    int n;
    imp_exp = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd0};
    modelClear();

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_ch", 64'(out_ch), 64'd0);
    checkOutput("rst_coef_out", 64'(coef_out), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_en = 1'b1;

    $display("[TB] impulse response");
    applyCoef(8'd6); applyCoef(8'd5); applyCoef(8'd4);
    applyCoef(8'd3); applyCoef(8'd2); applyCoef(8'd1);
    @(negedge clk);
    checkOutput("coef_out_loaded", 64'(coef_out), 64'd6);
    obs_q.delete();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, (i == 0) ? 8'd1 : 8'd0, 1'b1, '0);
      drain();
    end
    for (int i = 0; i < 7; i++) checkNextObs("impulse", imp_exp[i], 2'd0);

    $display("[TB] channel isolation");
    applyStimulus(0, 8'd1, 1'b1, '0);  drain();
    applyStimulus(1, 8'd10, 1'b1, '0); drain();
    applyStimulus(0, 8'd0, 1'b1, '0);  drain();
    checkNextObs("iso_a", 18'd1, 2'd0);
    checkNextObs("iso_b", 18'd10, 2'd1);
    checkNextObs("iso_c", 18'd2, 2'd0);

    $display("[TB] wrap with init value");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 8'd0, 1'b1, '0);
      drain();
    end
    obs_q.delete();
    applyStimulus(0, 8'd1, 1'b1, 18'h3FFFF);
    drain();
    checkNextObs("wrap", 18'h00000, 2'd0);

    $display("[TB] negative sample, both modes");
    applyStimulus(1, 8'hF6, 1'b1, '0); drain();
    applyStimulus(1, 8'h02, 1'b0, 18'd7); drain();
    checkNextObs("neg_tc1", 18'h3FFF6 + 18'd20, 2'd1);
    checkNextObs("pos_tc0", 18'd7 + 18'd2 + 18'd492 + 18'd30, 2'd1);

    $display("[TB] illegal channel discarded");
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = 8'h77;
    @(negedge clk);
    checkOutput("discard_ready_before", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("discard_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("discard_no_out", {63'd0, out_valid}, 64'd0);
    end

    $display("[TB] mixed vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(int'($urandom_range(0, 2)), DATA_W'($urandom), 1'($urandom), OUT_W'($urandom));
      drain();
    end

    $display("[TB] backpressure and coefficient freeze");
    @(posedge clk); #1 out_ready = 1'b0;
    applyStimulus(0, 8'd5, 1'b1, 18'd100);
    coef_shift_en = 1'b1;
    coef_in       = 8'h55;
    @(negedge clk);
    checkOutput("mac_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1 coef_shift_en = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_seen", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 coef_shift_en = (i == 5) || (i == 6);
      @(negedge clk);
      checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk); #1 coef_shift_en = 1'b0;
    @(negedge clk);
    checkOutput("coef_frozen", 64'(coef_out), 64'd6);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    $display("[TB] signed vs unsigned full-scale");
    doReset();
    for (int i = 0; i < ORDER; i++) applyCoef(8'hFF);
    applyStimulus(0, 8'hFF, 1'b1, '0);
    drain();
    checkNextObs("signed_ff", 18'd1, 2'd0);
    doReset();
    for (int i = 0; i < ORDER; i++) applyCoef(8'hFF);
    applyStimulus(0, 8'hFF, 1'b0, '0);
    drain();
    checkNextObs("unsigned_ff", 18'd65025, 2'd0);

    $display("[TB] reset during MAC");
    applyStimulus(0, 8'd3, 1'b1, '0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    obs_q.delete();
    modelClear();
    @(negedge clk);
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_coef_out", 64'(coef_out), 64'd0);
    checkOutput("midrst_out_data", 64'(out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(0, 8'd1, 1'b1, '0);
    drain();
    checkNextObs("post_reset", 18'd0, 2'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
